// File: rtl/r22sdf_ctrl_if.sv
// Bundles the input handshake, the stage controls and the output flags of the
// radix-2^2 SDF sequencer. The controller sits on the slave side.
interface r22sdf_ctrl_if #(
  parameter int FFT_POINTS = 64
);
  localparam int L  = $clog2(FFT_POINTS);
  localparam int NS = L / 2;

  logic          din_valid;
  logic          din_last;
  logic          din_ready;
  logic          dp_en;
  logic [NS-1:0] sel_bf2i;
  logic [NS-1:0] sel_bf2ii;
  logic [NS-1:0] jmul_bf2ii;
  logic          dout_valid;
  logic          dout_sof;
  logic [L-1:0]  dout_index;
  logic          busy;

  modport master (
    output din_valid, din_last,
    input  din_ready, dp_en, sel_bf2i, sel_bf2ii, jmul_bf2ii,
    input  dout_valid, dout_sof, dout_index, busy
  );

  modport slave (
    input  din_valid, din_last,
    output din_ready, dp_en, sel_bf2i, sel_bf2ii, jmul_bf2ii,
    output dout_valid, dout_sof, dout_index, busy
  );
endinterface

// File: rtl/r22sdf_ctrl.sv
// Sequencer for an N-point radix-2^2 SDF FFT: stage selects, datapath enable, flush
// and output tagging. Define R22SDF_CTRL_BITREV_EN to report dout_index bit-reversed.
module r22sdf_ctrl #(
  parameter int FFT_POINTS = 64,
  parameter int EXTRA_LAT  = 0
) (
  input logic          sys_clk,
  input logic          sys_nrst,
  r22sdf_ctrl_if.slave bus
);
  localparam int L   = $clog2(FFT_POINTS);
  localparam int NS  = L / 2;
  localparam int LAT = FFT_POINTS - 1 + EXTRA_LAT;
  localparam int LW  = $clog2(LAT + 1);
  localparam logic [LW-1:0] LAT_V = LW'(LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [L-1:0]  cnt_q, cnt_d;
  logic [L-1:0]  out_cnt_q, out_cnt_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [LW-1:0] flush_cnt_q, flush_cnt_d;

  logic          din_ready;
  logic          dp_en;
  logic          dout_valid;
  logic [NS-1:0] sel_bf2i;
  logic [NS-1:0] sel_bf2ii;
  logic [NS-1:0] jmul_bf2ii;
  logic [L-1:0]  dout_index;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_cnt_q   <= out_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_cnt_d   = out_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    flush_cnt_d = flush_cnt_q;

    din_ready  = (state_q != FLUSH);
    dp_en      = (state_q == FLUSH) | bus.din_valid;
    dout_valid = dp_en & (lat_cnt_q == LAT_V);

    // N is a power of two, so the natural L-bit wrap gives N-1 -> 0.
    if (dp_en) begin
      cnt_d = cnt_q + L'(1);
      if (lat_cnt_q != LAT_V) lat_cnt_d = lat_cnt_q + LW'(1);
    end
    if (dout_valid) out_cnt_d = out_cnt_q + L'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.din_valid) begin
          if (bus.din_last) begin
            state_d     = FLUSH;
            flush_cnt_d = LAT_V;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.din_valid && bus.din_last) begin
          state_d     = FLUSH;
          flush_cnt_d = LAT_V;
        end
      end
      FLUSH: begin
        // The counter reaches zero on the last flush cycle, so the drain spans LAT cycles.
        flush_cnt_d = flush_cnt_q - LW'(1);
        if (flush_cnt_q == LW'(1)) begin
          state_d     = IDLE;
          cnt_d       = '0;
          lat_cnt_d   = '0;
          out_cnt_d   = '0;
          flush_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage s pairs with counter bits L-1-2s (BF2I) and L-2-2s (BF2II).
  always_comb begin
    sel_bf2i   = '0;
    sel_bf2ii  = '0;
    jmul_bf2ii = '0;
    for (int s = 0; s < NS; s++) begin
      sel_bf2i[s]   = cnt_q[L-1-2*s];
      sel_bf2ii[s]  = cnt_q[L-2-2*s];
      jmul_bf2ii[s] = cnt_q[L-1-2*s] & ~cnt_q[L-2-2*s];
    end
  end

`ifdef R22SDF_CTRL_BITREV_EN
  always_comb begin
    dout_index = '0;
    for (int i = 0; i < L; i++) dout_index[i] = out_cnt_q[L-1-i];
  end
`else
  assign dout_index = out_cnt_q;
`endif

  assign bus.din_ready  = din_ready;
  assign bus.dp_en      = dp_en;
  assign bus.sel_bf2i   = sel_bf2i;
  assign bus.sel_bf2ii  = sel_bf2ii;
  assign bus.jmul_bf2ii = jmul_bf2ii;
  assign bus.dout_valid = dout_valid;
  assign bus.dout_sof   = dout_valid & (out_cnt_q == '0);
  assign bus.dout_index = dout_index;
  assign bus.busy       = (state_q != IDLE);
endmodule
